// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-mode encodings and arbiter states.
package dmem_pkg;

  localparam logic [2:0] MODE_NONE = 3'b000;
  localparam logic [2:0] MODE_W    = 3'b001;
  localparam logic [2:0] MODE_H    = 3'b010;
  localparam logic [2:0] MODE_B    = 3'b011;
  localparam logic [2:0] MODE_HU   = 3'b100;
  localparam logic [2:0] MODE_BU   = 3'b101;

  typedef enum logic [1:0] {
    S_CPU,
    S_AUX,
    S_ACK
  } arb_state_t;

  // Mode 000 is a no-op access: it must never reach the memory as a write.
  function automatic logic mode_is_access(logic [2:0] mode);
    return mode != MODE_NONE;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU MEM stage and an auxiliary master; the CPU owns it by
// default and the aux port is guaranteed a single-cycle slot after a bounded number of waits.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [2:0]       cpu_mode,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             aux_req,
  input  logic             aux_we,
  input  logic [2:0]       aux_mode,
  input  logic [WIDTH-1:0] aux_addr,
  input  logic [WIDTH-1:0] aux_wdata,
  output logic             aux_ack,
  output logic [WIDTH-1:0] aux_rdata,
  output logic             mem_we,
  output logic [2:0]       mem_mode,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int unsigned    CntW     = $clog2(MAX_WAIT) + 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(MAX_WAIT - 1);

  arb_state_t       state_q, state_d;
  logic [CntW-1:0]  wait_cnt_q, wait_cnt_d;
  logic             aux_ack_q, aux_ack_d;
  logic [WIDTH-1:0] aux_rdata_q, aux_rdata_d;

  logic             aux_sel;
  logic             sel_req;
  logic             sel_we;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    aux_ack_d   = 1'b0;
    aux_rdata_d = aux_rdata_q;
    unique case (state_q)
      S_CPU: begin
        if (aux_req && (!cpu_req || wait_cnt_q == WaitLast)) begin
          state_d    = S_AUX;
          wait_cnt_d = '0;
        end else if (aux_req && cpu_req && wait_cnt_q != WaitLast) begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      S_AUX: begin
        state_d     = S_ACK;
        aux_ack_d   = 1'b1;
        aux_rdata_d = mem_rdata;
      end
      // Aux stays ineligible here so a request still held during its ack is not re-granted.
      S_ACK: state_d = S_CPU;
      default: state_d = S_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CPU;
      wait_cnt_q  <= '0;
      aux_ack_q   <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      aux_ack_q   <= aux_ack_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  always_comb begin
    aux_sel   = (state_q == S_AUX);
    sel_req   = aux_sel ? aux_req   : cpu_req;
    sel_we    = aux_sel ? aux_we    : cpu_we;
    mem_mode  = aux_sel ? aux_mode  : cpu_mode;
    mem_addr  = aux_sel ? aux_addr  : cpu_addr;
    mem_wdata = aux_sel ? aux_wdata : cpu_wdata;
    // rst_n gates the strobe directly so nothing is written while reset is held.
    mem_we    = sel_req && sel_we && mode_is_access(mem_mode) && rst_n;
    cpu_stall = cpu_req && aux_sel;
    cpu_rdata = mem_rdata;
  end

  assign aux_ack   = aux_ack_q;
  assign aux_rdata = aux_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-addressed memory model, per-cycle reference model of
// ownership/ack/read-data, and literal checks on the latencies and stalls of each scenario.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned MaxWait = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [2:0]  cpu_mode, aux_mode;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic [31:0] cpu_rdata, aux_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, aux_ack, mem_we;
  logic [2:0]  mem_mode;

  int n_checks = 0;
  int n_errors = 0;
  int cpu_idx  = 0;
  int lat;

  logic        obs_stall [20];
  logic        obs_we    [20];
  logic [31:0] obs_addr  [20];
  logic [31:0] obs_wdata [20];

  logic [7:0] mem [512] = '{default: 8'h00};

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(32), .MAX_WAIT(MaxWait)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_mode  (cpu_mode),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .aux_req   (aux_req),
    .aux_we    (aux_we),
    .aux_mode  (aux_mode),
    .aux_addr  (aux_addr),
    .aux_wdata (aux_wdata),
    .aux_ack   (aux_ack),
    .aux_rdata (aux_rdata),
    .mem_we    (mem_we),
    .mem_mode  (mem_mode),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] mem_read(input logic [31:0] addr, input logic [2:0] mode);
    logic [8:0] a;
    logic [7:0] b0, b1, b2, b3;
    a  = addr[8:0];
    b0 = mem[a];
    b1 = mem[a + 9'd1];
    b2 = mem[a + 9'd2];
    b3 = mem[a + 9'd3];
    case (mode)
      MODE_W:  return {b3, b2, b1, b0};
      MODE_H:  return {{16{b1[7]}}, b1, b0};
      MODE_HU: return {16'h0, b1, b0};
      MODE_B:  return {{24{b0[7]}}, b0};
      MODE_BU: return {24'h0, b0};
      default: return 32'h0;
    endcase
  endfunction

  always_comb mem_rdata = mem_read(mem_addr, mem_mode);

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_mode)
        MODE_W: begin
          mem[mem_addr[8:0]]         <= mem_wdata[7:0];
          mem[mem_addr[8:0] + 9'd1]  <= mem_wdata[15:8];
          mem[mem_addr[8:0] + 9'd2]  <= mem_wdata[23:16];
          mem[mem_addr[8:0] + 9'd3]  <= mem_wdata[31:24];
        end
        MODE_H, MODE_HU: begin
          mem[mem_addr[8:0]]         <= mem_wdata[7:0];
          mem[mem_addr[8:0] + 9'd1]  <= mem_wdata[15:8];
        end
        MODE_B, MODE_BU: mem[mem_addr[8:0]] <= mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time-stamped view of the aux request. The aux port owns the memory in the
  // cycle after it is picked; it is picked on an idle CPU cycle or once it has waited MaxWait-1
  // busy cycles; the ack follows ownership, and the ack cycle itself is ineligible.
  int          cyc = 0;
  bit          m_own = 0, m_ack = 0, m_ackcyc = 0;
  int          m_wait_start = -1;
  logic [31:0] m_rdata = '0;

  always @(negedge clk) begin
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_mode;
    if (!rst_n) begin
      m_own = 0; m_ack = 0; m_ackcyc = 0; m_wait_start = -1; m_rdata = '0;
    end
    e_addr  = m_own ? aux_addr  : cpu_addr;
    e_wdata = m_own ? aux_wdata : cpu_wdata;
    e_mode  = m_own ? aux_mode  : cpu_mode;
    e_we    = rst_n && (m_own ? (aux_req && aux_we && aux_mode != MODE_NONE)
                              : (cpu_req && cpu_we && cpu_mode != MODE_NONE));
    chk("model_mem_addr", mem_addr, e_addr);
    chk("model_mem_wdata", mem_wdata, e_wdata);
    chk("model_mem_mode", 32'(mem_mode), 32'(e_mode));
    chk("model_mem_we", 32'(mem_we), 32'(e_we));
    chk("model_cpu_stall", 32'(cpu_stall), 32'(cpu_req && m_own));
    chk("model_aux_ack", 32'(aux_ack), 32'(m_ack));
    chk("model_aux_rdata", aux_rdata, m_rdata);
    if (!m_own) chk("model_cpu_rdata", cpu_rdata, mem_read(cpu_addr, cpu_mode));
    if (rst_n) begin
      if (m_own) begin
        m_rdata  = mem_read(aux_addr, aux_mode);
        m_ack    = 1;
        m_own    = 0;
        m_ackcyc = 1;
      end else if (m_ackcyc) begin
        m_ack    = 0;
        m_ackcyc = 0;
      end else begin
        m_ack = 0;
        if (aux_req) begin
          if (m_wait_start < 0) m_wait_start = cyc;
          if (!cpu_req || (cyc - m_wait_start) >= int'(MaxWait) - 1) begin
            m_own        = 1;
            m_wait_start = -1;
          end
        end else begin
          m_wait_start = -1;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu_store();
    cpu_we    = 1'b1;
    cpu_mode  = MODE_W;
    cpu_addr  = 32'h180 + 32'(4 * cpu_idx);
    cpu_wdata = 32'hC0DE0000 + 32'(cpu_idx);
  endtask

  // Called at the start of a cycle; records per-cycle observations until the ack, then drops
  // the request at the start of the following cycle. With stream set, the CPU issues stores
  // following pat and holds its access while stalled.
  task automatic aux_access(input bit stream, input logic [19:0] pat, input logic we,
                            input logic [2:0] mode, input logic [31:0] addr,
                            input logic [31:0] wdata, output int ack_cyc);
    aux_req = 1'b1; aux_we = we; aux_mode = mode; aux_addr = addr; aux_wdata = wdata;
    if (stream) begin
      cpu_req = pat[0];
      drive_cpu_store();
    end
    ack_cyc = -1;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      obs_stall[k] = cpu_stall;
      obs_we[k]    = mem_we;
      obs_addr[k]  = mem_addr;
      obs_wdata[k] = mem_wdata;
      if (aux_ack) ack_cyc = k;
      tick();
      if (stream) begin
        if (cpu_req && !obs_stall[k]) cpu_idx++;
        cpu_req = obs_stall[k] ? 1'b1 : pat[k+1];
        drive_cpu_store();
      end
      if (ack_cyc >= 0) break;
    end
    aux_req = 1'b0;
    if (ack_cyc < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL aux_ack_timeout: got no ack in 19 cycles, expected one");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_mode = MODE_W; cpu_addr = 32'h80;
    cpu_wdata = 32'h12345678;
    aux_req = 1'b0; aux_we = 1'b0; aux_mode = MODE_NONE; aux_addr = '0; aux_wdata = '0;

    // Reset with an active CPU store.
    repeat (2) @(negedge clk);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("reset_aux_ack", 32'(aux_ack), 32'd0);
    chk("reset_aux_rdata", aux_rdata, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'h80);
    tick();
    rst_n = 1'b1; cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_mode = MODE_B; cpu_addr = 32'h10; cpu_wdata = 32'hA5;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("reset_no_write", mem_read(32'h80, MODE_W), 32'd0);
    chk("cpu_byte_store", mem_read(32'h10, MODE_W), 32'hA5);

    // Aux alone.
    aux_access(1'b0, 20'h0, 1'b1, MODE_W, 32'h40, 32'hDEADBEEF, lat);
    chk("alone_ack_cycle", 32'(lat), 32'd2);
    chk("alone_c0_we", 32'(obs_we[0]), 32'd0);
    chk("alone_c1_we", 32'(obs_we[1]), 32'd1);
    chk("alone_c1_addr", obs_addr[1], 32'h40);
    chk("alone_c1_wdata", obs_wdata[1], 32'hDEADBEEF);
    @(negedge clk);
    chk("alone_ack_single", 32'(aux_ack), 32'd0);
    chk("alone_mem", mem_read(32'h40, MODE_W), 32'hDEADBEEF);
    tick();

    // Contention: CPU stores every cycle, two back-to-back aux accesses.
    cpu_idx = 0;
    aux_access(1'b1, 20'hFFFFF, 1'b1, MODE_W, 32'h44, 32'h0BADF00D, lat);
    chk("con_ack_cycle", 32'(lat), 32'(MaxWait + 1));
    for (int k = 0; k < 4; k++) chk("con_no_stall", 32'(obs_stall[k]), 32'd0);
    chk("con_stall_c4", 32'(obs_stall[4]), 32'd1);
    chk("con_stall_c5", 32'(obs_stall[5]), 32'd0);
    chk("con_c3_cpu_addr", obs_addr[3], 32'h18C);
    chk("con_c4_aux_addr", obs_addr[4], 32'h44);
    aux_access(1'b1, 20'hFFFFF, 1'b0, MODE_W, 32'h44, 32'h0, lat);
    chk("con2_ack_cycle", 32'(lat), 32'(MaxWait + 1));
    cpu_req = 1'b0;
    @(negedge clk);
    chk("con2_load", aux_rdata, 32'h0BADF00D);
    tick();
    for (int i = 0; i < 10; i++)
      chk("con_cpu_stores", mem_read(32'h180 + 32'(4 * i), MODE_W), 32'hC0DE0000 + 32'(i));

    // Aux BU load; data must persist until the next ack.
    aux_access(1'b0, 20'h0, 1'b0, MODE_BU, 32'h10, 32'h0, lat);
    chk("bu_ack_cycle", 32'(lat), 32'd2);
    @(negedge clk);
    chk("bu_rdata", aux_rdata, 32'hA5);
    repeat (4) tick();
    @(negedge clk);
    chk("bu_rdata_held", aux_rdata, 32'hA5);
    tick();

    // CPU busy two cycles then idle: aux slips in early.
    cpu_idx = 12;
    aux_access(1'b1, 20'b1011, 1'b0, MODE_W, 32'h40, 32'h0, lat);
    chk("mix_ack_cycle", 32'(lat), 32'd4);
    chk("mix_stall_c3", 32'(obs_stall[3]), 32'd1);
    chk("mix_stall_c2", 32'(obs_stall[2]), 32'd0);
    cpu_req = 1'b0;

    // Mode 000 aux write.
    aux_access(1'b0, 20'h0, 1'b1, MODE_NONE, 32'h48, 32'h55555555, lat);
    chk("none_ack_cycle", 32'(lat), 32'd2);
    for (int k = 0; k < 3; k++) chk("none_no_we", 32'(obs_we[k]), 32'd0);
    @(negedge clk);
    chk("none_rdata", aux_rdata, 32'h0);
    chk("none_mem", mem_read(32'h48, MODE_W), 32'h0);
    tick();

    // Reset during the grant cycle.
    aux_req = 1'b1; aux_we = 1'b1; aux_mode = MODE_W; aux_addr = 32'h4C;
    aux_wdata = 32'h77777777;
    @(negedge clk);
    tick();
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_mode = MODE_W; cpu_addr = 32'h50;
    cpu_wdata = 32'h99999999;
    @(negedge clk);
    chk("rst_aux_mem_we", 32'(mem_we), 32'd0);
    chk("rst_aux_stall", 32'(cpu_stall), 32'd0);
    chk("rst_aux_ack", 32'(aux_ack), 32'd0);
    chk("rst_aux_mem_addr", mem_addr, 32'h50);
    tick();
    @(negedge clk);
    chk("rst_aux_no_ack", 32'(aux_ack), 32'd0);
    tick();
    aux_req = 1'b0; rst_n = 1'b1; cpu_req = 1'b0;
    repeat (2) tick();
    chk("rst_aux_no_write", mem_read(32'h4C, MODE_W), 32'h0);
    chk("rst_cpu_no_write", mem_read(32'h50, MODE_W), 32'h0);
    cpu_idx = 20;
    aux_access(1'b1, 20'hFFFFF, 1'b0, MODE_W, 32'h4C, 32'h0, lat);
    chk("rst_wait_cleared", 32'(lat), 32'(MaxWait + 1));
    cpu_req = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
